// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC generator with prioritised trap/branch redirects, stall-held pending redirect and epoch
`ifndef PC_RESET
`define PC_RESET 32'h0000_2000
`endif
module fetch_pc_gen #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = `PC_RESET,
    parameter int IALIGN = 32,
    parameter int EPOCH_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               trap_valid,
    input  logic [XLEN-1:0]    trap_vector,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    next_pc,
    output logic [EPOCH_W-1:0] epoch,
    output logic               redirect_pending,
    output logic               target_misaligned
);
    localparam int LSB = (IALIGN == 16) ? 1 : 2;
    localparam logic [XLEN-1:0] MASK = ~((XLEN'(1) << LSB) - XLEN'(1));
    logic [XLEN-1:0]    r_pc;
    logic               r_pend_valid;
    logic               r_pend_trap;
    logic [XLEN-1:0]    r_pend_target;
    logic [EPOCH_W-1:0] r_epoch;
    logic [XLEN-1:0]    w_trap_t;
    logic [XLEN-1:0]    w_br_t;
    logic [XLEN-1:0]    w_sel;
    logic               w_redirect_sel;
    always_comb begin
        w_trap_t = trap_vector & MASK;
        w_br_t = redirect_target & MASK;
        w_sel = trap_valid ? w_trap_t : redirect_valid ? w_br_t : r_pend_valid ? r_pend_target : r_pc + XLEN'(4);
        w_redirect_sel = trap_valid | redirect_valid | r_pend_valid;
        next_pc = reset ? RESET_VECTOR : stall ? r_pc : w_sel;
        target_misaligned = !reset && (trap_valid ? |(trap_vector & ~MASK) : redirect_valid && |(redirect_target & ~MASK));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VECTOR - XLEN'(4);
            r_pend_valid <= 1'b0;
            r_pend_trap <= 1'b0;
            r_pend_target <= '0;
            r_epoch <= '0;
        end else if (!stall) begin
            r_pc <= w_sel;
            r_pend_valid <= 1'b0;
            if (w_redirect_sel) r_epoch <= r_epoch + EPOCH_W'(1);
        end else if (trap_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_trap <= 1'b1;
            r_pend_target <= w_trap_t;
        end else if (redirect_valid && !(r_pend_valid && r_pend_trap)) begin
            // a held trap is never displaced by a later branch
            r_pend_valid <= 1'b1;
            r_pend_trap <= 1'b0;
            r_pend_target <= w_br_t;
        end
    end
    assign pc = r_pc;
    assign epoch = r_epoch;
    assign redirect_pending = r_pend_valid;
endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised fetch program-counter generator for the pipelined core. It produces the instruction-memory fetch address (`next_pc`) and the registered address of the instruction now returned by synchronous IMEM (`pc`). It merges trap and branch/jump redirects by fixed priority and holds a redirect that arrives during a stall until the stall releases. It also maintains a redirect epoch so downstream stages can squash stale instructions.

## Interface
- `XLEN`, 32, address width.
- `RESET_VECTOR`, `` `PC_RESET ``, first fetch address after reset.
- `IALIGN`, 32, instruction alignment in bits. Must be 16 or 32. Redirect targets have the low `log2(IALIGN/8)` bits cleared.
- `EPOCH_W`, 2, epoch counter width (≥1).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the fetch address.
- `trap_valid` in 1: trap/exception redirect request.
- `trap_vector` in XLEN: trap target.
- `redirect_valid` in 1: branch/jump redirect request (taken branch, JAL, JALR).
- `redirect_target` in XLEN: raw ALU target.
- `pc` out XLEN: registered fetch address of the previous accepted cycle.
- `next_pc` out XLEN: fetch address presented to IMEM this cycle.
- `epoch` out EPOCH_W: current redirect epoch.
- `redirect_pending` out 1: a redirect is held across a stall.
- `target_misaligned` out 1: combinational; the chosen redirect target had nonzero cleared bits.

## Operation
- Internal state:
  - `pc_q`
  - `pend_valid`, `pend_trap`, `pend_target`
  - `epoch_q`
- Define `mask(t)` = t with the low `log2(IALIGN/8)` bits zeroed.
- Selected target `sel`, by priority:
  1. `trap_valid` → `mask(trap_vector)`
  2. `redirect_valid` → `mask(redirect_target)`
  3. `pend_valid` → `pend_target`
  4. otherwise `pc_q + 4`, modulo 2^XLEN; wrap from `all-ones-3` to 0 is legal and silent.
- Let `redirect_sel` = selection came from 1, 2 or 3.
- `next_pc`:
  - reset: `RESET_VECTOR`
  - else if stall: `pc_q`
  - else: `sel`
- While stalled, `next_pc` repeats `pc_q`, so IMEM re-fetches and holds its output stable.
- `pc` = `pc_q`.
- Register update:
  - Reset: `pc_q <= RESET_VECTOR - 4`, `pend_valid <= 0`, `pend_trap <= 0`, `pend_target <= 0`, `epoch_q <= 0`.
  - No stall: `pc_q <= sel`; `pend_valid <= 0`; if `redirect_sel`, `epoch_q <= epoch_q + 1` (wraps mod 2^EPOCH_W).
  - Stall with `trap_valid`: `pend_valid <= 1`, `pend_trap <= 1`, `pend_target <= mask(trap_vector)`. Overwrites any pending entry.
  - Stall with `redirect_valid` only: capture as a branch (`pend_trap <= 0`) unless `pend_valid & pend_trap`. A pending trap is never displaced by a branch.
  - Stall with no request: pending state and `pc_q` unchanged.
- Epoch advances once per applied redirect, not on capture.
- Two redirects during one stall window cost one epoch increment.
- `redirect_pending` = `pend_valid`.
- `target_misaligned`:
  - asserted when `trap_valid` and `trap_vector` low bits ≠ 0;
  - else when `redirect_valid` and `redirect_target` low bits ≠ 0;
  - independent of stall; forced 0 during reset.
  - Informational only; the target is still masked and used.

## Timing
- Reset values:
  - `pc` = `RESET_VECTOR-4`
  - `next_pc` = `RESET_VECTOR`
  - `epoch` = 0
  - `redirect_pending` = 0
  - `target_misaligned` = 0
- First cycle after reset deasserts (no stall): `next_pc` = `RESET_VECTOR`, because `sel` = `pc_q+4`.
- Redirect latency: a request in cycle N with no stall appears on `next_pc` in cycle N, combinationally, and on `pc` in N+1.
- Redirect during stall:
  - Cycles N..M-1 stalled, stall released in cycle M.
  - `next_pc` = `pending_target` in cycle M, unless a new trap/redirect in M outranks it.
  - `pc` = target in M+1; `redirect_pending` falls in M+1.
- Simultaneous `trap_valid` and `redirect_valid`: trap wins, both stalled and unstalled.
- Reset mid-stall or with a pending redirect: reset wins and all state is cleared next edge.
- No combinational path from `stall` to `pc`. `next_pc` depends combinationally on all inputs.

## Test plan
- Reset then free-run (`RESET_VECTOR=0x2000`), 3 cycles no stall → `next_pc` 0x2000, 0x2004, 0x2008; `pc` lags by one cycle; `epoch`=0.
- Redirect with `redirect_target=0x3007`, IALIGN=32, no stall → `next_pc`=0x3004 same cycle; `target_misaligned`=1; `pc`=0x3004 next cycle; `epoch` 0→1.
- Stall 3 cycles, `redirect_valid` pulse in the 2nd stall cycle to 0x4000:
  - `next_pc` held at `pc_q`; `redirect_pending`=1 from the next edge;
  - on release `next_pc`=0x4000, then 0x4004; `epoch` +1 exactly once.
- Stall:
  - with `trap_vector`=0x100 captured, then a branch to 0x5000 later in the same stall → release fetches 0x100.
  - Then trap + branch in the same unstalled cycle → `next_pc`=`trap_vector`.
- Epoch wrap, EPOCH_W=2: 5 consecutive unstalled redirects → `epoch` sequence 1,2,3,0,1.
- Assert `reset` while `redirect_pending`=1 and `pc`=0x4000 → next cycle `pc`=0x1FFC, `pending`=0, `epoch`=0, and `next_pc`=0x2000 throughout reset.
- IALIGN=16 variant: target 0x3003 → 0x3002 used; `target_misaligned`=1.
